// File: rtl/fwd_operand_stage_pkg.sv
// Shared constants for the EX-stage operand unit: forwarding select
// encodings and the hard-wired zero register.
package fwd_operand_stage_pkg;

   // Operand source selects, shared by both operands and visible on the ports.
   localparam logic [1:0] FWD_IDEX  = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_RSVD  = 2'b11;

   // Register 0 reads as zero: never forwarded, never a hazard source.
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_operand_stage_fwd_select.sv
// Per-operand forwarding: destination comparators, EX/MEM-over-MEM/WB
// priority encoder and the three-way operand mux.
module fwd_select
   import fwd_operand_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic [DATA_W-1:0] idex_data_i,
   input  logic              exmem_regwrite_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [DATA_W-1:0] exmem_data_i,
   input  logic              memwb_regwrite_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic [DATA_W-1:0] memwb_data_i,
   output logic [1:0]        sel_o,
   output logic [DATA_W-1:0] op_o
);

   localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

   logic exmem_hit;
   logic memwb_hit;

   assign exmem_hit = exmem_regwrite_i && (exmem_rd_i == src_i) && (src_i != RZ);
   assign memwb_hit = memwb_regwrite_i && (memwb_rd_i == src_i) && (src_i != RZ);

   // Youngest producer wins; with forwarding disabled the ID/EX copy is always used.
   always_comb begin
      sel_o = FWD_IDEX;
      if (FWD_EN) begin
         if (exmem_hit) begin
            sel_o = FWD_EXMEM;
         end else if (memwb_hit) begin
            sel_o = FWD_MEMWB;
         end
      end
   end

   // Operand mux; the reserved code falls back to the ID/EX copy.
   always_comb begin
      case (sel_o)
         FWD_EXMEM: op_o = exmem_data_i;
         FWD_MEMWB: op_o = memwb_data_i;
         default:   op_o = idex_data_i;
      endcase
   end

endmodule

// File: rtl/fwd_operand_stage.sv
// EX-stage operand unit: operand half of the ID/EX register, per-operand
// forwarding, load-use / RAW hazard stall with bubble insertion and a
// saturating stall-cycle counter.
module fwd_operand_stage
   import fwd_operand_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              flush,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_data,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic              stall,
   output logic              ex_valid,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_op_a,
   output logic [DATA_W-1:0] ex_op_b,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

   logic              ex_valid_q,     ex_valid_d;
   logic              ex_regwrite_q,  ex_regwrite_d;
   logic              ex_memread_q,   ex_memread_d;
   logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;
   logic [REG_AW-1:0] ex_rs_q,        ex_rs_d;
   logic [REG_AW-1:0] ex_rt_q,        ex_rt_d;
   logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
   logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
   logic [CNT_W-1:0]  stall_cnt_q,    stall_cnt_d;

   logic hazard;
   logic idex_uses;
   logic exmem_uses;
   logic memwb_uses;

   // Does an ID source read the register a given in-flight stage will write?
   assign idex_uses  = ex_valid_q && ex_regwrite_q && (ex_rd_q != RZ) &&
                       ((ex_rd_q == id_rs) || (ex_rd_q == id_rt));
   assign exmem_uses = exmem_regwrite && (exmem_rd != RZ) &&
                       ((exmem_rd == id_rs) || (exmem_rd == id_rt));
   assign memwb_uses = memwb_regwrite && (memwb_rd != RZ) &&
                       ((memwb_rd == id_rs) || (memwb_rd == id_rt));

   // Forwarding only leaves the load-use case; without it, every in-flight
   // writer (including MEM/WB, since the register file does not bypass) blocks.
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN) begin
         hazard = ex_valid_q && ex_memread_q && (ex_rd_q != RZ) &&
                  ((ex_rd_q == id_rs) || (ex_rd_q == id_rt));
      end else begin
         hazard = idex_uses || exmem_uses || memwb_uses;
      end
   end

   // A squashed or empty ID slot never stalls; reset forces the stall low too.
   assign stall = !rst && id_valid && !flush && hazard;

   // ID/EX next state: flush or stall loads a bubble, otherwise capture ID.
   always_comb begin
      ex_valid_d    = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      ex_rd_d       = '0;
      ex_rs_d       = '0;
      ex_rt_d       = '0;
      ex_rs_data_d  = '0;
      ex_rt_data_d  = '0;
      if (!flush && !stall) begin
         ex_valid_d    = id_valid;
         ex_regwrite_d = id_regwrite;
         ex_memread_d  = id_memread;
         ex_rd_d       = id_rd;
         ex_rs_d       = id_rs;
         ex_rt_d       = id_rt;
         ex_rs_data_d  = id_rs_data;
         ex_rt_data_d  = id_rt_data;
      end
   end

   // Stall-cycle counter holds at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // ID/EX operand register and stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_rd_q       <= '0;
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         ex_rs_data_q  <= '0;
         ex_rt_data_q  <= '0;
         stall_cnt_q   <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_regwrite_q <= ex_regwrite_d;
         ex_memread_q  <= ex_memread_d;
         ex_rd_q       <= ex_rd_d;
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         ex_rs_data_q  <= ex_rs_data_d;
         ex_rt_data_q  <= ex_rt_data_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .FWD_EN (FWD_EN)
   ) u_fwd_a (
      .src_i            (ex_rs_q),
      .idex_data_i      (ex_rs_data_q),
      .exmem_regwrite_i (exmem_regwrite),
      .exmem_rd_i       (exmem_rd),
      .exmem_data_i     (exmem_data),
      .memwb_regwrite_i (memwb_regwrite),
      .memwb_rd_i       (memwb_rd),
      .memwb_data_i     (memwb_data),
      .sel_o            (fwd_sel_a),
      .op_o             (ex_op_a)
   );

   fwd_select #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .FWD_EN (FWD_EN)
   ) u_fwd_b (
      .src_i            (ex_rt_q),
      .idex_data_i      (ex_rt_data_q),
      .exmem_regwrite_i (exmem_regwrite),
      .exmem_rd_i       (exmem_rd),
      .exmem_data_i     (exmem_data),
      .memwb_regwrite_i (memwb_regwrite),
      .memwb_rd_i       (memwb_rd),
      .memwb_data_i     (memwb_data),
      .sel_o            (fwd_sel_b),
      .op_o             (ex_op_b)
   );

   assign ex_valid    = ex_valid_q;
   assign ex_regwrite = ex_regwrite_q;
   assign ex_memread  = ex_memread_q;
   assign ex_rd       = ex_rd_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Bench for fwd_operand_stage. Three instances share all inputs:
//   0: forwarding on, 16-bit counter
//   1: forwarding off, 16-bit counter
//   2: forwarding off, 2-bit counter
module tb_fwd_operand_stage;

   localparam bit          FE   [3] = '{1'b1, 1'b0, 1'b0};
   localparam int unsigned CMAX [3] = '{65535, 65535, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid, id_regwrite, id_memread, flush;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_data, memwb_data;

   logic        stall_w [3];
   logic        exv_w   [3];
   logic        exrw_w  [3];
   logic        exmr_w  [3];
   logic [4:0]  exrd_w  [3];
   logic [31:0] opa_w   [3];
   logic [31:0] opb_w   [3];
   logic [1:0]  sela_w  [3];
   logic [1:0]  selb_w  [3];
   logic [15:0] cnt_w   [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam bit FEN = (g == 0);
      localparam int CW  = (g == 2) ? 2 : 16;
      logic [CW-1:0] cnt_l;
      fwd_operand_stage #(
         .DATA_W (32), .REG_AW (5), .FWD_EN (FEN), .CNT_W (CW)
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .id_valid       (id_valid),
         .id_rs          (id_rs),
         .id_rt          (id_rt),
         .id_rs_data     (id_rs_data),
         .id_rt_data     (id_rt_data),
         .id_rd          (id_rd),
         .id_regwrite    (id_regwrite),
         .id_memread     (id_memread),
         .flush          (flush),
         .exmem_regwrite (exmem_regwrite),
         .exmem_rd       (exmem_rd),
         .exmem_data     (exmem_data),
         .memwb_regwrite (memwb_regwrite),
         .memwb_rd       (memwb_rd),
         .memwb_data     (memwb_data),
         .stall          (stall_w[g]),
         .ex_valid       (exv_w[g]),
         .ex_regwrite    (exrw_w[g]),
         .ex_memread     (exmr_w[g]),
         .ex_rd          (exrd_w[g]),
         .ex_op_a        (opa_w[g]),
         .ex_op_b        (opb_w[g]),
         .fwd_sel_a      (sela_w[g]),
         .fwd_sel_b      (selb_w[g]),
         .stall_cnt      (cnt_l)
      );
      assign cnt_w[g] = 16'(cnt_l);
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic        v, rw, mr;
      logic [4:0]  rd, rs, rt;
      logic [31:0] rsd, rtd;
   } idex_t;

   idex_t       mq   [3];
   int unsigned mcnt [3];

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [1:0] m_sel(input int d, input logic [4:0] src);
      if (!FE[d] || src == 5'd0) return 2'b00;
      if (exmem_regwrite && exmem_rd == src) return 2'b10;
      if (memwb_regwrite && memwb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] m_op(input logic [1:0] s, input logic [31:0] own);
      if (s == 2'b10) return exmem_data;
      if (s == 2'b01) return memwb_data;
      return own;
   endfunction

   function automatic logic m_stall(input int d);
      logic [4:0] writers [$];
      if (!id_valid || flush) return 1'b0;
      if (FE[d])
         return mq[d].v && mq[d].mr && mq[d].rd != 5'd0 &&
                (mq[d].rd == id_rs || mq[d].rd == id_rt);
      if (mq[d].v && mq[d].rw) writers.push_back(mq[d].rd);
      if (exmem_regwrite)      writers.push_back(exmem_rd);
      if (memwb_regwrite)      writers.push_back(memwb_rd);
      foreach (writers[i])
         if (writers[i] != 5'd0 && (writers[i] == id_rs || writers[i] == id_rt)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         mq[d]   = '{default: '0};
         mcnt[d] = 0;
      end
   endtask

   task automatic chk_model(input int d);
      logic [1:0] sa, sb;
      sa = m_sel(d, mq[d].rs);
      sb = m_sel(d, mq[d].rt);
      chk($sformatf("d%0d sel_a", d), sela_w[d], sa);
      chk($sformatf("d%0d sel_b", d), selb_w[d], sb);
      chk($sformatf("d%0d op_a", d), opa_w[d], m_op(sa, mq[d].rsd));
      chk($sformatf("d%0d op_b", d), opb_w[d], m_op(sb, mq[d].rtd));
      chk($sformatf("d%0d stall", d), stall_w[d], m_stall(d));
      chk($sformatf("d%0d ex_valid", d), exv_w[d], mq[d].v);
      chk($sformatf("d%0d ex_regwrite", d), exrw_w[d], mq[d].rw);
      chk($sformatf("d%0d ex_memread", d), exmr_w[d], mq[d].mr);
      chk($sformatf("d%0d ex_rd", d), exrd_w[d], mq[d].rd);
      chk($sformatf("d%0d stall_cnt", d), cnt_w[d], mcnt[d]);
   endtask

   // One clock: model next state from the inputs currently driven.
   task automatic step();
      idex_t nx [3];
      logic  st [3];
      for (int d = 0; d < 3; d++) begin
         st[d] = m_stall(d);
         if (flush || st[d]) nx[d] = '{default: '0};
         else nx[d] = '{v: id_valid, rw: id_regwrite, mr: id_memread, rd: id_rd,
                        rs: id_rs, rt: id_rt, rsd: id_rs_data, rtd: id_rt_data};
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         mq[d] = nx[d];
         if (st[d] && mcnt[d] < CMAX[d]) mcnt[d]++;
      end
      #1;
   endtask

   task automatic zero_inputs();
      id_valid = 0; id_regwrite = 0; id_memread = 0; flush = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
      exmem_regwrite = 0; exmem_rd = 0; exmem_data = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      zero_inputs();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic rw, input logic mr);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_regwrite = rw; id_memread = mr;
      id_rs_data = 32'h5000_0000 | 32'(rs);
      id_rt_data = 32'h7000_0000 | 32'(rt);
   endtask

   // ---------------- forwarding vectors ----------------
   typedef struct {
      logic [4:0] rs;
      logic       ex_rw;
      logic [4:0] ex_rd;
      logic       wb_rw;
      logic [4:0] wb_rd;
      logic [1:0] exp_sel;
   } fwd_vec_t;

   fwd_vec_t vecs [8];

   initial begin
      logic [31:0] own, exp_op;
      vecs[0] = '{5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 2'b10};
      vecs[1] = '{5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 2'b01};
      vecs[2] = '{5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00};
      vecs[3] = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 2'b00};
      vecs[4] = '{5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 2'b01};
      vecs[5] = '{5'd5, 1'b1, 5'd5, 1'b0, 5'd5, 2'b10};
      vecs[6] = '{5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 2'b10};
      vecs[7] = '{5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 2'b00};

      zero_inputs();
      model_reset();
      #1 rst = 1'b1;
      #2;
      for (int d = 0; d < 3; d++) chk_model(d);
      @(posedge clk);
      #1 rst = 1'b0;

      // Forwarding table.
      for (int i = 0; i < 8; i++) begin
         zero_inputs();
         drive_id(vecs[i].rs, 5'd0, 5'd0, 1'b0, 1'b0);
         own = id_rs_data;
         step();
         exmem_regwrite = vecs[i].ex_rw; exmem_rd = vecs[i].ex_rd;
         exmem_data = 32'hEEEE_0000 | 32'(i);
         memwb_regwrite = vecs[i].wb_rw; memwb_rd = vecs[i].wb_rd;
         memwb_data = 32'hBBBB_0000 | 32'(i);
         id_rs = vecs[i].rs; id_rt = vecs[i].rs;
         #1;
         case (vecs[i].exp_sel)
            2'b10:   exp_op = exmem_data;
            2'b01:   exp_op = memwb_data;
            default: exp_op = own;
         endcase
         chk($sformatf("vec%0d fwd sel_a", i), sela_w[0], vecs[i].exp_sel);
         chk($sformatf("vec%0d fwd op_a", i), opa_w[0], exp_op);
         chk($sformatf("vec%0d fwd stall", i), stall_w[0], 1'b0);
         chk($sformatf("vec%0d nofwd sel_a", i), sela_w[1], 2'b00);
         chk($sformatf("vec%0d nofwd op_a", i), opa_w[1], own);
         chk($sformatf("vec%0d nofwd stall", i), stall_w[1], vecs[i].exp_sel != 2'b00);
      end

      // Load-use on forwarding instance: one bubble, then MEM/WB forward.
      do_reset();
      drive_id(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
      #1 chk("lu no stall on load", stall_w[0], 1'b0);
      step();
      drive_id(5'd6, 5'd4, 5'd8, 1'b1, 1'b0);
      #1 chk("lu stall", stall_w[0], 1'b1);
      step();
      exmem_regwrite = 1; exmem_rd = 5'd4; exmem_data = 32'h100;
      #1;
      chk("lu bubble valid", exv_w[0], 1'b0);
      chk("lu cnt after bubble", cnt_w[0], 16'd1);
      chk("lu stall released", stall_w[0], 1'b0);
      step();
      exmem_regwrite = 0; memwb_regwrite = 1; memwb_rd = 5'd4; memwb_data = 32'hD00D;
      #1;
      chk("lu dep valid", exv_w[0], 1'b1);
      chk("lu dep rd", exrd_w[0], 5'd8);
      chk("lu sel_b", selb_w[0], 2'b01);
      chk("lu op_b", opb_w[0], 32'hD00D);
      chk("lu sel_a", sela_w[0], 2'b00);
      chk("lu cnt final", cnt_w[0], 16'd1);

      // Flush during load-use hazard.
      do_reset();
      drive_id(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
      step();
      drive_id(5'd6, 5'd4, 5'd8, 1'b1, 1'b0);
      flush = 1;
      #1;
      chk("flush stall fwd", stall_w[0], 1'b0);
      chk("flush stall nofwd", stall_w[1], 1'b0);
      step();
      flush = 0; id_valid = 0;
      #1;
      chk("flush bubble", exv_w[0], 1'b0);
      chk("flush cnt", cnt_w[0], 16'd0);

      // No forwarding: back-to-back dependency on r7 stalls three cycles.
      do_reset();
      drive_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
      #1 chk("raw first no stall", stall_w[1], 1'b0);
      step();
      drive_id(5'd7, 5'd3, 5'd9, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         exmem_regwrite = (k == 1); exmem_rd = 5'd7;
         memwb_regwrite = (k == 2); memwb_rd = 5'd7;
         #1 chk($sformatf("raw stall %0d", k), stall_w[1], 1'b1);
         step();
      end
      exmem_regwrite = 0; memwb_regwrite = 0;
      #1 chk("raw released", stall_w[1], 1'b0);
      step();
      chk("raw issued valid", exv_w[1], 1'b1);
      chk("raw issued rd", exrd_w[1], 5'd9);
      chk("raw sel_a", sela_w[1], 2'b00);
      chk("raw sel_b", selb_w[1], 2'b00);
      chk("raw cnt", cnt_w[1], 16'd3);

      // Saturation on the 2-bit counter.
      do_reset();
      drive_id(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      memwb_regwrite = 1; memwb_rd = 5'd5;
      #1 chk("sat stall", stall_w[2], 1'b1);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk($sformatf("sat cnt %0d", i), cnt_w[2], (i > 3) ? 16'd3 : 16'(i));
         chk($sformatf("wide cnt %0d", i), cnt_w[1], 16'(i));
      end

      // Mid-run asynchronous reset.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_id(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
         step();
         drive_id(5'd6, 5'd4, 5'd8, 1'b1, 1'b0);
         step();
         step();
      end
      chk("pre-rst cnt", cnt_w[0], 16'd5);
      chk("pre-rst valid", exv_w[0], 1'b1);
      exmem_regwrite = 1; exmem_rd = 5'd6; exmem_data = 32'h66;
      #1 chk("pre-rst sel_a", sela_w[0], 2'b10);
      #1 rst = 1'b1;
      #1;
      chk("rst valid", exv_w[0], 1'b0);
      chk("rst regwrite", exrw_w[0], 1'b0);
      chk("rst memread", exmr_w[0], 1'b0);
      chk("rst rd", exrd_w[0], 5'd0);
      chk("rst sel_a", sela_w[0], 2'b00);
      chk("rst sel_b", selb_w[0], 2'b00);
      chk("rst op_a", opa_w[0], 32'd0);
      chk("rst op_b", opb_w[0], 32'd0);
      chk("rst stall", stall_w[0], 1'b0);
      chk("rst cnt", cnt_w[0], 16'd0);
      do_reset();

      // Randomised traffic against the model on all three instances.
      for (int n = 0; n < 400; n++) begin
         id_valid       = ($urandom_range(0, 3) != 0);
         id_rs          = 5'($urandom_range(0, 7));
         id_rt          = 5'($urandom_range(0, 7));
         id_rd          = 5'($urandom_range(0, 7));
         id_regwrite    = 1'($urandom_range(0, 1));
         id_memread     = ($urandom_range(0, 2) == 0);
         id_rs_data     = $urandom;
         id_rt_data     = $urandom;
         flush          = ($urandom_range(0, 9) == 0);
         exmem_regwrite = 1'($urandom_range(0, 1));
         exmem_rd       = 5'($urandom_range(0, 7));
         exmem_data     = $urandom;
         memwb_regwrite = 1'($urandom_range(0, 1));
         memwb_rd       = 5'($urandom_range(0, 7));
         memwb_data     = $urandom;
         #1;
         for (int d = 0; d < 3; d++) chk_model(d);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
